mash_ratio_sequencer: RTL and testbench
=======================================

# mash_ratio_sequencer

Sequencer that owns the divide-ratio inputs (`in_i`, `in_f`) of the MASH 1-1-1 delta-sigma modulator top module. It accepts new target ratios over a valid/ready handshake and drives the modulator with the result. A target is either applied in one cycle or slewed toward in fixed fractional steps, with a programmable dwell between steps. This lets frequency hops be ramped without disturbing the PLL loop.

## Interface
- `RATIO_W`, 20: ratio word width, `{int[3:0], frac[15:0]}`.
- `STEP_W`, 16: ramp step width (fractional LSBs).
- `DWELL_W`, 8: dwell counter width.
- `RESET_RATIO`, 20'h7_0000: ratio driven out of reset (7.0).

- `clk`  input  1  system clock (500 MHz); the only clock.
- `rst`  input  1  reset, synchronous, active-high.
- `req_valid`  input  1  new target request.
- `req_ready`  output  1  sequencer can accept a request.
- `req_ratio`  input  RATIO_W  target ratio `{int, frac}`.
- `req_step`  input  STEP_W  ramp step size; 0 means jump immediately.
- `req_dwell`  input  DWELL_W  extra hold cycles between ramp steps.
- `in_i`  output  4  integer ratio to the modulator (registered).
- `in_f`  output  16  fractional ratio to the modulator (registered).
- `busy`  output  1  ramp in progress.
- `done`  output  1  one-cycle pulse when the output reaches the target.

## Operation
- **State.**
  - One 20-bit current-ratio register `cur`; `in_i = cur[19:16]` and `in_f = cur[15:0]`.
  - Target, step and dwell are latched on acceptance.
- **States:** IDLE, STEP, DWELL.
- **Handshake.**
  - `req_ready` = (state == IDLE).
  - A request is accepted when `req_valid && req_ready` at an edge.
  - `req_valid` while `req_ready` is low is ignored; it is neither queued nor an error.
- **IDLE, on accept:**
  - If target == `cur`: stay in IDLE; `done` pulses the next cycle.
  - Else if `req_step` == 0: `cur` <= target at the accept edge; `done` pulses; stay in IDLE.
  - Else: go to STEP.
- **STEP, each edge:**
  - Direction is up if target > `cur`, down otherwise.
  - Compute `cur ± step` in RATIO_W+1 bits, unsigned magnitude compare, no wrap.
  - If the result reaches or passes the target, `cur` <= target (clamped, never overshoots), `done` pulses, and the state goes to IDLE.
  - Otherwise `cur` <= result, and the state moves to DWELL with counter = `req_dwell`. If `req_dwell` == 0, stay in STEP instead.
- **DWELL:**
  - Counter decrements each edge.
  - At the edge where counter == 1 (decrements to 0), go to STEP.
  - Net effect: `cur` updates every `req_dwell`+1 cycles.
- **Integer borrow/carry** between `frac` and `int` is plain 20-bit arithmetic.
- `busy` = (state != IDLE).
- **Reset.**
  - `rst` high at an edge forces IDLE, `cur` = RESET_RATIO, `busy` = 0, `done` = 0, `req_ready` = 1.
  - This holds mid-ramp too: the ramp is abandoned and no `done` is issued.
  - Outputs, reset values: `in_i` = 4'h7, `in_f` = 0, `req_ready` = 1, `busy` = 0, `done` = 0.

## Timing
- Accept edge E0.
- Jump (step 0): new `in_i`/`in_f` visible after E0; `done` high for the cycle after E0.
- Ramp: first update at E1; the k-th update at E1 + (k-1)(dwell+1).
- `done` is high for exactly one cycle after the final update edge. `req_ready` is high in that same cycle, so a back-to-back request can be accepted at that edge.
- All outputs are registered; there is no combinational path from request inputs to outputs.

## Configuration
- Macro `MASH_RATIO_CLAMP_EN`.
- **Defined:** at acceptance, the target is clamped to the modulator's legal range.
  - int < 3 → 3.0000.
  - int > 11 → 11.0000, i.e. 20'hB_0000 (fraction forced to 0).
  - Otherwise unchanged.
- **Undefined:** the target is used as-is; legality is the requester's responsibility.

## Structure
- **Shared package `mash_ctrl_pkg`:**
  - state enum (IDLE/STEP/DWELL);
  - RATIO_W;
  - INT_MIN = 3, INT_MAX = 11;
  - default RESET_RATIO.
- **One sub-module, `mash_ratio_stepper`:**
  - combinational;
  - takes `cur`, target and step;
  - returns the next ratio (direction, add/sub, clamp) and a `reached` flag.

## Test plan
- **Reset:** hold `rst` for 2 cycles → `in_i` = 7, `in_f` = 0, `req_ready` = 1, `busy` = 0, `done` = 0. Repeat with `rst` asserted mid-ramp → same values next cycle, no `done`.
- **Jump:** ratio 20'h5_8000, step 0 → `in_i` = 5, `in_f` = 16'h8000 after E0; `done` one cycle; `busy` never high.
- **Up ramp:**
  - Setup: from 7.0, ratio 20'h7_0300, step 16'h100, dwell 2.
  - Expected: `in_f` = 16'h100/16'h200/16'h300 after E1/E4/E7; `done` after E7.
- **Down ramp with borrow and clamp:**
  - Setup: from 20'h8_0000, target 20'h7_FE00, step 16'h180, dwell 0.
  - Expected: 20'h7_FE80 at E1, 20'h7_FE00 at E2 (clamped), then `done`.
- **Busy rejection:** `req_valid` pulsed during a ramp → `req_ready` low, target unchanged, ramp completes to the original target.
- **Clamp macro:** with `MASH_RATIO_CLAMP_EN`, request 20'hE_0000 with step 0 → `in_i` = 11, `in_f` = 0. Without the macro → `in_i` = 14.

Source files
------------

// File: rtl/mash_ctrl_pkg.sv
// mash_ctrl_pkg: shared sequencer states, ratio width, legal integer range and reset ratio
package mash_ctrl_pkg;

    localparam int RATIO_W = 20;
    localparam int INT_MIN = 3;
    localparam int INT_MAX = 11;
    localparam logic [RATIO_W-1:0] RESET_RATIO = 20'h7_0000;

    typedef enum logic [1:0] {IDLE, STEP, DWELL} state_t;

    function automatic logic [RATIO_W-1:0] clamp_ratio(input logic [RATIO_W-1:0] r);
        logic [3:0] ip;
        ip = r[RATIO_W-1 -: 4];
        if (ip < 4'(INT_MIN)) return {4'(INT_MIN), {(RATIO_W-4){1'b0}}};
        if (ip > 4'(INT_MAX)) return {4'(INT_MAX), {(RATIO_W-4){1'b0}}};
        return r;
    endfunction

endpackage

// File: rtl/mash_ratio_stepper.sv
// mash_ratio_stepper: one ramp step from cur toward tgt, clamped so it never overshoots
module mash_ratio_stepper #(
    parameter int RATIO_W = 20,
    parameter int STEP_W  = 16
) (
    input  logic [RATIO_W-1:0] cur,
    input  logic [RATIO_W-1:0] tgt,
    input  logic [STEP_W-1:0]  step,
    output logic [RATIO_W-1:0] nxt,
    output logic               reached
);

    logic              up;
    logic [RATIO_W:0]  stp;
    logic [RATIO_W:0]  sum;

    // one extra bit catches carry-out on the way up and borrow on the way down
    always_comb begin
        up      = tgt > cur;
        stp     = (RATIO_W+1)'(step);
        sum     = up ? {1'b0, cur} + stp : {1'b0, cur} - stp;
        reached = up ? (sum >= {1'b0, tgt}) : (sum[RATIO_W] || sum <= {1'b0, tgt});
        nxt     = reached ? tgt : sum[RATIO_W-1:0];
    end

endmodule

// File: rtl/mash_ratio_sequencer.sv
// mash_ratio_sequencer: drives the MASH divide ratio, jumping or ramping to requested targets
// Optional target range clamp at acceptance: define MASH_RATIO_CLAMP_EN
module mash_ratio_sequencer #(
    parameter int                              RATIO_W     = mash_ctrl_pkg::RATIO_W,
    parameter int                              STEP_W      = 16,
    parameter int                              DWELL_W     = 8,
    parameter logic [mash_ctrl_pkg::RATIO_W-1:0] RESET_RATIO = mash_ctrl_pkg::RESET_RATIO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [RATIO_W-1:0] req_ratio,
    input  logic [STEP_W-1:0]  req_step,
    input  logic [DWELL_W-1:0] req_dwell,
    output logic [3:0]         in_i,
    output logic [RATIO_W-5:0] in_f,
    output logic               busy,
    output logic               done
);

    import mash_ctrl_pkg::*;

    state_t             state, state_n;
    logic [RATIO_W-1:0] cur, cur_n, tgt, tgt_n, req_tgt, step_nxt;
    logic [STEP_W-1:0]  step, step_n;
    logic [DWELL_W-1:0] dwell, dwell_n, cnt, cnt_n;
    logic               done_n, reached;

`ifdef MASH_RATIO_CLAMP_EN
    assign req_tgt = clamp_ratio(req_ratio);
`else
    assign req_tgt = req_ratio;
`endif

    assign in_i      = cur[RATIO_W-1 -: 4];
    assign in_f      = cur[RATIO_W-5:0];
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;

    mash_ratio_stepper #(.RATIO_W(RATIO_W), .STEP_W(STEP_W)) u_stepper (
        .cur     (cur),
        .tgt     (tgt),
        .step    (step),
        .nxt     (step_nxt),
        .reached (reached)
    );

    // state and ratio registers; reset abandons any ramp without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur   <= RESET_RATIO;
            tgt   <= RESET_RATIO;
            step  <= '0;
            dwell <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            tgt   <= tgt_n;
            step  <= step_n;
            dwell <= dwell_n;
            cnt   <= cnt_n;
            done  <= done_n;
        end
    end

    // accept, step and dwell sequencing; the stepper already clamps the final update to tgt
    always_comb begin
        state_n = state;
        cur_n   = cur;
        tgt_n   = tgt;
        step_n  = step;
        dwell_n = dwell;
        cnt_n   = cnt;
        done_n  = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                tgt_n   = req_tgt;
                step_n  = req_step;
                dwell_n = req_dwell;
                if (req_tgt == cur) done_n = 1'b1;
                else if (req_step == '0) begin
                    cur_n  = req_tgt;
                    done_n = 1'b1;
                end else state_n = STEP;
            end
            STEP: begin
                cur_n   = step_nxt;
                cnt_n   = dwell;
                done_n  = reached;
                state_n = reached ? IDLE : (dwell == '0 ? STEP : DWELL);
            end
            DWELL: begin
                cnt_n   = cnt - 1'b1;
                state_n = cnt == DWELL_W'(1) ? STEP : DWELL;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mash_ratio_sequencer.sv
// tb_mash_ratio_sequencer: scoreboard bench for jump, ramps, rejection, reset and clamp
module tb_mash_ratio_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [19:0] req_ratio = '0;
    logic [15:0] req_step = '0;
    logic [7:0]  req_dwell = '0;
    logic [3:0]  in_i;
    logic [15:0] in_f;
    logic        busy;
    logic        done;

    typedef struct {
        logic [19:0] cur;
        logic        done;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

`ifdef MASH_RATIO_CLAMP_EN
    localparam logic [19:0] HI_EXP = 20'hB_0000;
    localparam logic [19:0] LO_EXP = 20'h3_0000;
`else
    localparam logic [19:0] HI_EXP = 20'hE_0000;
    localparam logic [19:0] LO_EXP = 20'h1_8000;
`endif

    mash_ratio_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ratio (req_ratio),
        .req_step  (req_step),
        .req_dwell (req_dwell),
        .in_i      (in_i),
        .in_f      (in_f),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [19:0] ratio,
                       input logic [15:0] st, input logic [7:0] dw,
                       input logic [19:0] ecur, input logic edone, input logic ebusy);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_ratio = ratio;
        req_step  = st;
        req_dwell = dw;
        sb.push_back('{ecur, edone, ebusy});
    endtask

    task automatic wt(input logic [19:0] ecur, input logic edone, input logic ebusy);
        cyc(1'b0, 1'b0, 20'h0, 16'h0, 8'h0, ecur, edone, ebusy);
    endtask

    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("ratio", {12'h0, in_i, in_f}, {12'h0, e.cur});
            check_eq("done", {31'h0, done}, {31'h0, e.done});
            check_eq("busy", {31'h0, busy}, {31'h0, e.busy});
            check_eq("ready", {31'h0, req_ready}, {31'h0, !e.busy});
        end
    end

    initial begin
        cyc(1, 0, 20'h0, 16'h0, 8'h0, 20'h7_0000, 0, 0);
        cyc(1, 0, 20'h0, 16'h0, 8'h0, 20'h7_0000, 0, 0);
        wt(20'h7_0000, 0, 0);
        cyc(0, 1, 20'h5_8000, 16'h0, 8'h0, 20'h5_8000, 1, 0);
        wt(20'h5_8000, 0, 0);
        cyc(0, 1, 20'h5_8000, 16'h10, 8'h0, 20'h5_8000, 1, 0);
        wt(20'h5_8000, 0, 0);
        cyc(0, 1, 20'h7_0000, 16'h0, 8'h0, 20'h7_0000, 1, 0);
        cyc(0, 1, 20'h7_0300, 16'h100, 8'h2, 20'h7_0000, 0, 1);
        wt(20'h7_0100, 0, 1);
        cyc(0, 1, 20'h2_0000, 16'h0, 8'h0, 20'h7_0100, 0, 1);
        wt(20'h7_0100, 0, 1);
        wt(20'h7_0200, 0, 1);
        wt(20'h7_0200, 0, 1);
        wt(20'h7_0200, 0, 1);
        wt(20'h7_0300, 1, 0);
        cyc(0, 1, 20'h8_0000, 16'h0, 8'h0, 20'h8_0000, 1, 0);
        cyc(0, 1, 20'h7_FE00, 16'h180, 8'h0, 20'h8_0000, 0, 1);
        wt(20'h7_FE80, 0, 1);
        wt(20'h7_FE00, 1, 0);
        wt(20'h7_FE00, 0, 0);
        cyc(0, 1, 20'h9_0000, 16'h4000, 8'h1, 20'h7_FE00, 0, 1);
        wt(20'h8_3E00, 0, 1);
        wt(20'h8_3E00, 0, 1);
        cyc(1, 0, 20'h0, 16'h0, 8'h0, 20'h7_0000, 0, 0);
        wt(20'h7_0000, 0, 0);
        wt(20'h7_0000, 0, 0);
        cyc(0, 1, 20'hE_0000, 16'h0, 8'h0, HI_EXP, 1, 0);
        wt(HI_EXP, 0, 0);
        cyc(0, 1, 20'h1_8000, 16'h0, 8'h0, LO_EXP, 1, 0);
        wt(LO_EXP, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        check_eq("drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
